dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port data memory.
- Requester 0 is the core load/store path; requester 1 is a debug/DMA master.
- Accepts one request at a time with round-robin fairness, drives the memory port for exactly one cycle, captures read data, and returns a held response through a valid/ready handshake.
- Sits between the requesters and D_Mem; the memory-side ports connect directly to the D_Mem inputs and output.

---
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/response and memory-side bus of the data-memory
// arbiter. The slave modport is the arbiter's view; the master modport is
// the environment view (requesters plus D_Mem).
interface dmem_arbiter_if #(
  parameter int ADDR_W  = 14,
  parameter int NUM_REQ = 2
);

  // Requester side
  logic [NUM_REQ-1:0]             ReqValid;
  logic [NUM_REQ-1:0]             ReqReady;
  logic [NUM_REQ-1:0][ADDR_W-1:0] ReqAddr;
  logic [NUM_REQ-1:0][31:0]       ReqData;
  logic [NUM_REQ-1:0][3:0]        ReqByteEn;
  logic [NUM_REQ-1:0]             ReqWrEn;

  // Response side (data and error are shared between requesters)
  logic [NUM_REQ-1:0]             RspValid;
  logic [NUM_REQ-1:0]             RspReady;
  logic [31:0]                    RspData;
  logic                           RspErr;

  // Memory side, wired straight to the D_Mem ports
  logic [ADDR_W-1:0]              DMemAddress;
  logic [31:0]                    DMemData;
  logic [3:0]                     DMemByteEn;
  logic                           DMemWrEn;
  logic                           DMemRdEn;
  logic [31:0]                    DMemRspData;

  modport slave (
    input  ReqValid, ReqAddr, ReqData, ReqByteEn, ReqWrEn,
    input  RspReady,
    input  DMemRspData,
    output ReqReady,
    output RspValid, RspData, RspErr,
    output DMemAddress, DMemData, DMemByteEn, DMemWrEn, DMemRdEn
  );

  modport master (
    output ReqValid, ReqAddr, ReqData, ReqByteEn, ReqWrEn,
    output RspReady,
    output DMemRspData,
    input  ReqReady,
    input  RspValid, RspData, RspErr,
    input  DMemAddress, DMemData, DMemByteEn, DMemWrEn, DMemRdEn
  );

endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter and sequencer in front of
// the single-port data memory. One request is accepted at a time, the memory
// port is driven for exactly one cycle, and the response is held on a
// valid/ready handshake until the winning requester consumes it.
//
// Optional feature: define DMEM_ARB_BE_CHECK_EN to check byte-enable
// legality and alignment; illegal requests skip the memory access and
// respond with RspErr=1 and RspData=0. Without it RspErr is tied to 0.
module dmem_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int NUM_REQ = 2
) (
  input logic           Clk,
  input logic           Rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  // Round-robin pointer: id of the requester that wins a tie.
  logic               rr_ptr;

  // Latched request and the id of the requester being served.
  logic               winner;
  logic [ADDR_W-1:0]  lat_addr;
  logic [31:0]        lat_data;
  logic [3:0]         lat_be;
  logic               lat_wr;

  // Held response data.
  logic [31:0]        rsp_data;

  // Arbitration results for the current cycle.
  logic [NUM_REQ-1:0] grant;
  logic               grant_id;
  logic               handshake;

  // Response consumed by the winning requester.
  logic               rsp_ack;

  // Latched request is allowed to touch memory.
  logic               be_ok;

`ifdef DMEM_ARB_BE_CHECK_EN
  logic               rsp_err;

  // Legal byte enables: single byte anywhere, aligned halfword, aligned word.
  always_comb begin
    be_ok = 1'b0;
    unique case (lat_be)
      4'b0001: be_ok = 1'b1;
      4'b0011: be_ok = (lat_addr[0] == 1'b0);
      4'b1111: be_ok = (lat_addr[1:0] == 2'b00);
      default: be_ok = 1'b0;
    endcase
  end

  // Error flag is captured with the access and held through the response.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rsp_err <= 1'b0;
    end else if (state == ACCESS) begin
      rsp_err <= ~be_ok;
    end
  end

  assign bus.RspErr = rsp_err;
`else
  assign be_ok      = 1'b1;
  assign bus.RspErr = 1'b0;
`endif

  // Round-robin winner selection; only offered while idle.
  always_comb begin
    grant    = '0;
    grant_id = 1'b0;
    if (state == IDLE) begin
      unique case (bus.ReqValid)
        2'b01: begin
          grant    = 2'b01;
          grant_id = 1'b0;
        end
        2'b10: begin
          grant    = 2'b10;
          grant_id = 1'b1;
        end
        2'b11: begin
          grant    = rr_ptr ? 2'b10 : 2'b01;
          grant_id = rr_ptr;
        end
        default: begin
          grant    = '0;
          grant_id = 1'b0;
        end
      endcase
    end
  end

  assign handshake = |grant;
  assign rsp_ack   = bus.RspReady[winner];

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> ACCESS -> RESP -> IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (handshake) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (rsp_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winning request and hand priority to the other requester.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rr_ptr   <= 1'b0;
      winner   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_be   <= '0;
      lat_wr   <= 1'b0;
    end else if (handshake) begin
      rr_ptr   <= ~grant_id;
      winner   <= grant_id;
      lat_addr <= bus.ReqAddr[grant_id];
      lat_data <= bus.ReqData[grant_id];
      lat_be   <= bus.ReqByteEn[grant_id];
      lat_wr   <= bus.ReqWrEn[grant_id];
    end
  end

  // Capture read data at the end of the access; writes and rejected
  // requests return zero.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rsp_data <= '0;
    end else if (state == ACCESS) begin
      if (lat_wr || !be_ok) begin
        rsp_data <= '0;
      end else begin
        rsp_data <= bus.DMemRspData;
      end
    end
  end

  // Handshake and memory-port outputs; the memory port is quiet outside
  // ACCESS so reset silences it immediately.
  always_comb begin
    bus.ReqReady    = grant;
    bus.RspValid    = '0;
    bus.RspData     = rsp_data;
    bus.DMemAddress = '0;
    bus.DMemData    = '0;
    bus.DMemByteEn  = '0;
    bus.DMemWrEn    = 1'b0;
    bus.DMemRdEn    = 1'b0;
    if (state == ACCESS) begin
      bus.DMemAddress = lat_addr;
      bus.DMemData    = lat_data;
      bus.DMemByteEn  = lat_be;
      bus.DMemWrEn    = lat_wr & be_ok;
      bus.DMemRdEn    = ~lat_wr & be_ok;
    end
    if (state == RESP) begin
      bus.RspValid = winner ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a
// byte-lane memory model standing in for D_Mem.
module tb_dmem_arbiter;

  localparam int ADDR_W = 14;

  logic Clk = 1'b0;
  logic Rst;

  int errors = 0;
  int checks = 0;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .NUM_REQ(2)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .NUM_REQ(2)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  // Memory model: word-aligned lanes, combinational read, clocked write.
  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic              pre_en;
  logic [ADDR_W-1:0] pre_addr;
  logic [31:0]       pre_data;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [ADDR_W-1:0] p0, p1, p2, p3;

  assign a0 = {bus.DMemAddress[ADDR_W-1:2], 2'd0};
  assign a1 = {bus.DMemAddress[ADDR_W-1:2], 2'd1};
  assign a2 = {bus.DMemAddress[ADDR_W-1:2], 2'd2};
  assign a3 = {bus.DMemAddress[ADDR_W-1:2], 2'd3};
  assign p0 = {pre_addr[ADDR_W-1:2], 2'd0};
  assign p1 = {pre_addr[ADDR_W-1:2], 2'd1};
  assign p2 = {pre_addr[ADDR_W-1:2], 2'd2};
  assign p3 = {pre_addr[ADDR_W-1:2], 2'd3};

  always_comb bus.DMemRspData = {mem[a3], mem[a2], mem[a1], mem[a0]};

  always @(posedge Clk) begin
    if (pre_en) begin
      mem[p0] <= pre_data[7:0];
      mem[p1] <= pre_data[15:8];
      mem[p2] <= pre_data[23:16];
      mem[p3] <= pre_data[31:24];
    end else if (bus.DMemWrEn) begin
      if (bus.DMemByteEn[0]) mem[a0] <= bus.DMemData[7:0];
      if (bus.DMemByteEn[1]) mem[a1] <= bus.DMemData[15:8];
      if (bus.DMemByteEn[2]) mem[a2] <= bus.DMemData[23:16];
      if (bus.DMemByteEn[3]) mem[a3] <= bus.DMemData[31:24];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction for requester id (which must be the expected
  // winner): handshake, access, bp cycles of response backpressure, ack.
  task automatic txn(input logic id, input logic [ADDR_W-1:0] addr,
                     input logic [31:0] data, input logic [3:0] be,
                     input logic wr, input logic [1:0] valid, input logic hold,
                     input int bp, input logic exp_acc,
                     input logic [31:0] exp_rsp, input logic exp_err);
    logic [1:0] onehot;
    onehot = 2'(2'b01 << id);
    bus.ReqAddr[id]   = addr;
    bus.ReqData[id]   = data;
    bus.ReqByteEn[id] = be;
    bus.ReqWrEn[id]   = wr;
    bus.ReqValid      = valid;
    #1;
    check("req_ready_grant", 32'(bus.ReqReady), 32'(onehot));
    @(posedge Clk); #1;
    if (!hold) bus.ReqValid[id] = 1'b0;
    #1;
    check("access_req_ready", 32'(bus.ReqReady), 32'd0);
    check("access_rden", 32'(bus.DMemRdEn), 32'(exp_acc & ~wr));
    check("access_wren", 32'(bus.DMemWrEn), 32'(exp_acc & wr));
    check("access_addr", 32'(bus.DMemAddress), 32'(addr));
    check("access_be", 32'(bus.DMemByteEn), 32'(be));
    if (wr) check("access_wdata", bus.DMemData, data);
    @(posedge Clk); #1;
    for (int c = 0; c <= bp; c++) begin
      check("rsp_valid", 32'(bus.RspValid), 32'(onehot));
      check("rsp_data", bus.RspData, exp_rsp);
      check("rsp_err", 32'(bus.RspErr), 32'(exp_err));
      check("rsp_enables", 32'({bus.DMemWrEn, bus.DMemRdEn}), 32'd0);
      check("rsp_req_ready", 32'(bus.ReqReady), 32'd0);
      if (c < bp) begin
        @(posedge Clk); #1;
      end
    end
    bus.RspReady = 2'b11;
    @(posedge Clk); #1;
    bus.RspReady = 2'b00;
    check("rsp_done", 32'(bus.RspValid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst           = 1'b1;
    bus.ReqValid  = '0;
    bus.ReqAddr   = '0;
    bus.ReqData   = '0;
    bus.ReqByteEn = '0;
    bus.ReqWrEn   = '0;
    bus.RspReady  = '0;
    pre_en        = 1'b0;
    pre_addr      = '0;
    pre_data      = '0;

    // Reset values and memory preload
    @(posedge Clk); #1;
    pre_en   = 1'b1;
    pre_addr = 14'h10;
    pre_data = 32'h44332211;
    @(posedge Clk); #1;
    pre_en = 1'b0;
    check("reset_rsp_valid", 32'(bus.RspValid), 32'd0);
    check("reset_rsp_data", bus.RspData, 32'd0);
    check("reset_rsp_err", 32'(bus.RspErr), 32'd0);
    check("reset_dmem", 32'({bus.DMemWrEn, bus.DMemRdEn, bus.DMemByteEn}), 32'd0);
    check("reset_dmem_addr", 32'(bus.DMemAddress), 32'd0);
    Rst = 1'b0;
    #1;
    check("idle_req_ready", 32'(bus.ReqReady), 32'd0);

    // Single read by requester 0
    txn(1'b0, 14'h10, 32'h0, 4'hF, 1'b0, 2'b01, 1'b0, 0, 1'b1, 32'h44332211, 1'b0);

    // Write then read by requester 1
    txn(1'b1, 14'h20, 32'hDEADBEEF, 4'hF, 1'b1, 2'b10, 1'b0, 0, 1'b1, 32'h0, 1'b0);
    check("wr_wren_off", 32'(bus.DMemWrEn), 32'd0);
    check("mem_after_write", {mem[14'h23], mem[14'h22], mem[14'h21], mem[14'h20]}, 32'hDEADBEEF);
    txn(1'b1, 14'h20, 32'h0, 4'hF, 1'b0, 2'b10, 1'b0, 0, 1'b1, 32'hDEADBEEF, 1'b0);

    // Response backpressure with the other requester waiting
    bus.ReqAddr[1]   = 14'h20;
    bus.ReqByteEn[1] = 4'hF;
    bus.ReqWrEn[1]   = 1'b0;
    txn(1'b0, 14'h10, 32'h0, 4'hF, 1'b0, 2'b11, 1'b0, 5, 1'b1, 32'h44332211, 1'b0);
    bus.ReqValid = '0;

    // Contention from reset: grant order 0,1,0,1
    Rst = 1'b1;
    #3;
    Rst = 1'b0;
    bus.ReqAddr[0]   = 14'h10;
    bus.ReqByteEn[0] = 4'hF;
    bus.ReqWrEn[0]   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0)
        txn(1'b0, 14'h10, 32'h0, 4'hF, 1'b0, 2'b11, 1'b1, 0, 1'b1, 32'h44332211, 1'b0);
      else
        txn(1'b1, 14'h20, 32'h0, 4'hF, 1'b0, 2'b11, 1'b1, 0, 1'b1, 32'hDEADBEEF, 1'b0);
    end
    bus.ReqValid = '0;

    // Async reset during ACCESS, pointer left at 1 by the handshake
    bus.ReqAddr[0]   = 14'h10;
    bus.ReqByteEn[0] = 4'hF;
    bus.ReqWrEn[0]   = 1'b0;
    bus.ReqValid     = 2'b01;
    #1;
    check("rst_pre_grant", 32'(bus.ReqReady), 32'd1);
    @(posedge Clk); #1;
    bus.ReqValid = '0;
    #1;
    check("rst_pre_rden", 32'(bus.DMemRdEn), 32'd1);
    Rst = 1'b1;
    #1;
    check("rst_enables", 32'({bus.DMemWrEn, bus.DMemRdEn}), 32'd0);
    check("rst_rsp_valid", 32'(bus.RspValid), 32'd0);
    check("rst_rsp_data", bus.RspData, 32'd0);
    @(posedge Clk); #2;
    Rst          = 1'b0;
    bus.ReqValid = 2'b11;
    #1;
    check("rst_ptr_zero", 32'(bus.ReqReady), 32'd1);
    bus.ReqValid = '0;
    @(posedge Clk); #1;
    check("rst_still_idle", 32'(bus.DMemRdEn), 32'd0);

    // Halfword write to an odd address
`ifdef DMEM_ARB_BE_CHECK_EN
    txn(1'b0, 14'h21, 32'h12345678, 4'b0011, 1'b1, 2'b01, 1'b0, 0, 1'b0, 32'h0, 1'b1);
    check("be_mem_b0", 32'(mem[14'h20]), 32'hEF);
    check("be_mem_b1", 32'(mem[14'h21]), 32'hBE);
`else
    txn(1'b0, 14'h21, 32'h12345678, 4'b0011, 1'b1, 2'b01, 1'b0, 0, 1'b1, 32'h0, 1'b0);
    check("be_mem_b0", 32'(mem[14'h20]), 32'h78);
    check("be_mem_b1", 32'(mem[14'h21]), 32'h56);
`endif
    check("be_mem_b2", 32'(mem[14'h22]), 32'hAD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
